// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bundle: PC mux feedback, instruction-memory read port and decode handshake.
// The fetch unit takes the master view; the surrounding pipeline and memory take the slave view.
interface pc_fetch_unit_if;
    logic [31:0] pc_next;
    logic        pc_redirect;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        ir_ready;

    modport master (
        input  pc_next, pc_redirect, imem_rvalid, imem_rdata, ir_ready,
        output pc_out, pc_plus4, imem_req, imem_addr, ir_valid, ir_data, ir_pc
    );

    modport slave (
        output pc_next, pc_redirect, imem_rvalid, imem_rdata, ir_ready,
        input  pc_out, pc_plus4, imem_req, imem_addr, ir_valid, ir_data, ir_pc
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer with redirect handling.
// A redirect while a read is in flight leaves a stale response that is swallowed in StDrop.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_data_q;
    logic [31:0] ir_pc_q;
    logic [31:0] pc_target;

    assign pc_target    = {bus.pc_next[31:2], 2'b00};

    assign bus.pc_out    = pc_q;
    assign bus.pc_plus4  = pc_q + 32'd4;
    assign bus.imem_addr = pc_q;
    assign bus.imem_req  = (state_q == StFetch) && !bus.pc_redirect;
    assign bus.ir_valid  = (state_q == StHold);
    assign bus.ir_data   = ir_data_q;
    assign bus.ir_pc     = ir_pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= {RESET_VEC[31:2], 2'b00};
            state_q   <= StFetch;
            ir_data_q <= 32'd0;
            ir_pc_q   <= 32'd0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (bus.pc_redirect) begin
                        pc_q <= pc_target;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.pc_redirect) begin
                        pc_q    <= pc_target;
                        state_q <= bus.imem_rvalid ? StFetch : StDrop;
                    end else if (bus.imem_rvalid) begin
                        ir_data_q <= bus.imem_rdata;
                        ir_pc_q   <= pc_q;
                        state_q   <= StHold;
                    end
                end
                StHold: begin
                    // Redirect beats accept: the held instruction is squashed.
                    if (bus.pc_redirect) begin
                        pc_q    <= pc_target;
                        state_q <= StFetch;
                    end else if (bus.ir_ready) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= StFetch;
                    end
                end
                StDrop: begin
                    if (bus.pc_redirect) begin
                        pc_q <= pc_target;
                    end
                    if (bus.imem_rvalid) begin
                        state_q <= StFetch;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer, directly downstream of the PC select mux.
- Holds the architectural PC and issues one instruction-memory read at a time.
- Handles variable memory latency and presents the fetched instruction to decode with a valid/ready handshake.
- Feeds PC and PC+4 back to the mux inputs.
- Takes the mux output as the redirect target for branches, jumps and traps.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  synchronous reset, active low
PC_NEXT  in  32  redirect target from PC select mux
PC_REDIRECT  in  1  1 = load PC_NEXT this cycle (branch taken/jump/trap)
PC_OUT  out  32  current PC register value
PC_PLUS4  out  32  PC_OUT + 4, combinational, to mux sequential input
IMEM_REQ  out  1  read request, single-cycle strobe
IMEM_ADDR  out  32  read address, equals PC_OUT
IMEM_RVALID  in  1  read data valid, single-cycle strobe
IMEM_RDATA  in  32  read data
IR_VALID  out  1  instruction available to decode
IR_DATA  out  32  fetched instruction
IR_PC  out  32  address of IR_DATA
IR_READY  in  1  decode accepts instruction

Behaviour:
- Reset (RST_N=0 at edge): PC<=RESET_VEC, state<=FETCH, IR_VALID/IR_DATA/IR_PC<=0. Overrides everything, including mid-request; memory shares the reset.
- PC loads mask bits [1:0] to 00. PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Single outstanding request maximum. Memory returns exactly one IMEM_RVALID ≥1 cycle after an accepted IMEM_REQ.
- IMEM_REQ = (state==FETCH) & ~PC_REDIRECT (combinational). IMEM_ADDR = PC_OUT always.
- IR_VALID = (state==HOLD), registered state decode.
- FETCH:
  - PC_REDIRECT=1: PC<=PC_NEXT, no request issued, stay FETCH.
  - Otherwise: request issued, go WAIT.
  - IMEM_RVALID here is ignored.
- WAIT:
  - Redirect priority: PC_REDIRECT=1 → PC<=PC_NEXT; if IMEM_RVALID same cycle, discard data and go FETCH, else go DROP.
  - Else IMEM_RVALID=1 → IR_DATA<=IMEM_RDATA, IR_PC<=PC, go HOLD.
  - Else stay.
- HOLD:
  - PC_REDIRECT=1 (priority over IR_READY): PC<=PC_NEXT, go FETCH; IR_VALID low next cycle, instruction not consumed.
  - Else IR_READY=1: PC<=PC+4, go FETCH.
  - Else hold IR_DATA/IR_PC stable.
- DROP (stale response pending):
  - IMEM_RVALID=1 → discard, go FETCH.
  - PC_REDIRECT in DROP: PC<=PC_NEXT, stay DROP; if simultaneous with RVALID, load and go FETCH.
- Latency with 1-cycle memory: REQ cycle n, RVALID n+1, IR_VALID n+2; accept at n+2 → next REQ n+3. Peak throughput 1 instr / 3 cycles.
- No IR_DATA/IR_PC change while IR_VALID=1 except via redirect or accept.

Test Plan:
- Reset: RST_N=0 2 cycles, RESET_VEC=32'h0000_0100 → PC_OUT=0x100, IR_VALID=0; first cycle after release IMEM_REQ=1, IMEM_ADDR=0x100.
- Sequential fetch, 1-cycle memory returning 0x00000013, IR_READY tied 1 → IR_PC sequence 0x100, 0x104, 0x108, one IR_VALID pulse every 3 cycles, IR_DATA=0x13.
- Stall: IR_READY=0 for 5 cycles in HOLD → IR_VALID stays 1, IR_DATA/IR_PC unchanged, no IMEM_REQ, PC_OUT=0x100. Then IR_READY=1 → PC_OUT=0x104.
- Redirect mid-request: memory latency 4, PC_REDIRECT=1 with PC_NEXT=0x2000 one cycle after REQ → stale RVALID dropped with no IR_VALID, next REQ at 0x2000, IR_PC=0x2000.
- Redirect vs accept in HOLD: IR_READY=1 and PC_REDIRECT=1 with PC_NEXT=0x3003 same cycle → PC_OUT=0x3000 (low bits masked), not IR_PC+4.
- Wrap and mid-op reset: PC=0xFFFF_FFFC accepted → PC_OUT=0. RST_N=0 during WAIT → PC=RESET_VEC, state FETCH, IR_VALID=0.
